pwm_gen: RTL and testbench

- Tick-driven PWM generator that sits directly downstream of the frequency divider.
- Consumes the divider's one-cycle clk_div pulse as its tick enable.
- Produces a PWM waveform with a period of 2^WIDTH ticks and a programmable duty.
- Duty is double-buffered: a new duty written at any time takes effect only at the next period boundary, so the output never glitches mid-period.

---
 rtl/pwm_gen_pkg.sv | 24 ++
 rtl/pwm_gen_duty_shadow.sv | 63 ++++++
 rtl/pwm_gen.sv | 103 ++++++++++
 tb/tb_pwm_gen.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pwm_gen_pkg.sv
// Shared definitions for the tick-driven PWM generator.
//   state_t   : controller state (IDLE / RUN)
//   PERIOD    : period length in ticks for the default counter width
//   sat_duty  : clamps a requested duty to the full-period maximum 2^width
package pwm_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int unsigned WIDTH_DEFAULT = 8;
    localparam int unsigned PERIOD        = 2 ** WIDTH_DEFAULT;

    // Duty values above a full period would mean "more than always on";
    // they are clamped so the compare against the counter stays meaningful.
    function automatic logic [31:0] sat_duty(input logic [31:0] duty,
                                             input int unsigned width);
        logic [31:0] limit;
        limit = 32'd1 << width;
        return (duty > limit) ? limit : duty;
    endfunction

endpackage

// File: rtl/pwm_gen_duty_shadow.sv
// Double-buffered duty register for pwm_gen.
// Holds a pending duty until the next apply edge (period wrap or IDLE->RUN),
// then promotes it to the active duty. A write landing on an apply edge
// bypasses the pending register and loads the active duty directly.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   apply             : this edge is a period boundary (wrap or start)
//   duty_wr           : one-cycle write strobe
//   duty_sat          : already-saturated write value
//   duty_active       : duty in use for the current period
//   duty_active_next  : value duty_active takes on the coming edge
//   duty_busy         : a written duty is pending
//   duty_ack          : one-cycle pulse after a new duty becomes active
module duty_shadow #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             apply,
    input  logic             duty_wr,
    input  logic [WIDTH:0]   duty_sat,
    output logic [WIDTH:0]   duty_active,
    output logic [WIDTH:0]   duty_active_next,
    output logic             duty_busy,
    output logic             duty_ack
);

    logic [WIDTH:0] duty_pend;
    logic           pend_flag;

    // A write on the apply edge wins over an older pending value.
    always_comb begin
        duty_active_next = duty_active;
        if (apply) begin
            if (duty_wr) begin
                duty_active_next = duty_sat;
            end else if (pend_flag) begin
                duty_active_next = duty_pend;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_active <= '0;
            duty_pend   <= '0;
            pend_flag   <= 1'b0;
            duty_ack    <= 1'b0;
        end else begin
            duty_active <= duty_active_next;
            duty_ack    <= apply && (duty_wr || pend_flag);
            if (apply) begin
                pend_flag <= 1'b0;
            end else if (duty_wr) begin
                duty_pend <= duty_sat;
                pend_flag <= 1'b1;
            end
        end
    end

    assign duty_busy = pend_flag;

endmodule

// File: rtl/pwm_gen.sv
// Tick-driven PWM generator. The counter advances on each divider tick while
// running; period is 2^WIDTH ticks. Duty is double-buffered in duty_shadow so
// a new value only takes effect at a period boundary.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   tick        : one-cycle advance enable from the divider
//   en          : run request; 0 returns to IDLE
//   duty_wr     : one-cycle write strobe for duty_in
//   duty_in     : requested high time in ticks (saturates to 2^WIDTH)
//   duty_busy   : a written duty is pending
//   duty_ack    : one-cycle pulse after a pending duty becomes active
//   period_end  : one-cycle pulse the cycle after the counter wraps
//   pwm_out     : registered PWM output
module pwm_gen
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             en,
    input  logic             duty_wr,
    input  logic [WIDTH:0]   duty_in,
    output logic             duty_busy,
    output logic             duty_ack,
    output logic             period_end,
    output logic             pwm_out
);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_next;
    logic             wrap;
    logic             apply;
    logic             pwm_next;
    logic [WIDTH:0]   duty_sat;
    logic [WIDTH:0]   duty_active;
    logic [WIDTH:0]   duty_active_next;

    assign duty_sat = (WIDTH + 1)'(sat_duty(32'(duty_in), WIDTH));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = en ? RUN : IDLE;
            RUN:     state_next = en ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output / datapath decode
    always_comb begin
        wrap     = (state == RUN) && en && tick && (cnt == '1);
        apply    = ((state == IDLE) && en) || wrap;
        cnt_next = cnt;
        if (state_next == IDLE) begin
            cnt_next = '0;
        end else if ((state == RUN) && tick) begin
            cnt_next = cnt + 1'b1;
        end
        // Compare against next-cycle values so pwm_out lines up with cnt.
        pwm_next = (state_next == RUN) && ({1'b0, cnt_next} < duty_active_next);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            pwm_out    <= 1'b0;
            period_end <= 1'b0;
        end else begin
            cnt        <= cnt_next;
            pwm_out    <= pwm_next;
            period_end <= wrap;
        end
    end

    duty_shadow #(
        .WIDTH (WIDTH)
    ) u_duty_shadow (
        .clk              (clk),
        .rst_n            (rst_n),
        .apply            (apply),
        .duty_wr          (duty_wr),
        .duty_sat         (duty_sat),
        .duty_active      (duty_active),
        .duty_active_next (duty_active_next),
        .duty_busy        (duty_busy),
        .duty_ack         (duty_ack)
    );

endmodule

// File: tb/tb_pwm_gen.sv
// Directed bench for pwm_gen with WIDTH=4 and a divide-by-3 tick source.
module tb_pwm_gen;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic       en;
    logic       duty_wr;
    logic [4:0] duty_in;
    logic       duty_busy;
    logic       duty_ack;
    logic       period_end;
    logic       pwm_out;

    logic [1:0] div = 2'd0;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic [4:0] duty;
        int         exp_hi;
    } vec_t;

    vec_t vecs [7];

    pwm_gen #(
        .WIDTH (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .en         (en),
        .duty_wr    (duty_wr),
        .duty_in    (duty_in),
        .duty_busy  (duty_busy),
        .duty_ack   (duty_ack),
        .period_end (period_end),
        .pwm_out    (pwm_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Divider model: one tick every 3 clocks.
    always @(posedge clk) div <= (div == 2'd2) ? 2'd0 : div + 2'd1;
    assign tick = (div == 2'd2);

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic wait_pe(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!period_end && n < 200);
        chk(name, int'(period_end), 1);
    endtask

    // Samples one 48-clock period window starting at the current sample,
    // optionally issuing writes at given sample indices.
    task automatic period_run(input int w1, input logic [4:0] v1,
                              input int w2, input logic [4:0] v2,
                              output int hi, output int pe,
                              output int ak, output int bz);
        hi = 0; pe = 0; ak = 0; bz = 0;
        for (int i = 0; i < 48; i++) begin
            hi += int'(pwm_out);
            pe += int'(period_end);
            ak += int'(duty_ack);
            bz += int'(duty_busy);
            duty_wr = 1'b0;
            if (i == w1) begin duty_wr = 1'b1; duty_in = v1; end
            if (i == w2) begin duty_wr = 1'b1; duty_in = v2; end
            @(negedge clk);
        end
        duty_wr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int hi, pe, ak, bz, ticks, n;

        vecs[0] = '{5'd4,  12};
        vecs[1] = '{5'd0,  0};
        vecs[2] = '{5'd16, 48};
        vecs[3] = '{5'd20, 48};
        vecs[4] = '{5'd1,  3};
        vecs[5] = '{5'd15, 45};
        vecs[6] = '{5'd4,  12};

        rst_n = 1'b1; en = 1'b0; duty_wr = 1'b0; duty_in = '0;
        #3 rst_n = 1'b0;
        #1;
        chk("reset_pwm",   int'(pwm_out),    0);
        chk("reset_pe",    int'(period_end), 0);
        chk("reset_ack",   int'(duty_ack),   0);
        chk("reset_busy",  int'(duty_busy),  0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_pwm", int'(pwm_out), 0);

        // Write coinciding with IDLE->RUN: loads directly, acked, never busy.
        en = 1'b1; duty_wr = 1'b1; duty_in = 5'd4;
        @(negedge clk);
        duty_wr = 1'b0;
        chk("start_ack",  int'(duty_ack),  1);
        chk("start_busy", int'(duty_busy), 0);
        chk("start_pwm",  int'(pwm_out),   1);

        foreach (vecs[k]) begin
            duty_wr = 1'b1; duty_in = vecs[k].duty;
            @(negedge clk);
            duty_wr = 1'b0;
            chk($sformatf("vec%0d_busy", k), int'(duty_busy), 1);
            wait_pe($sformatf("vec%0d_apply_pe", k));
            period_run(-1, '0, -1, '0, hi, pe, ak, bz);
            chk($sformatf("vec%0d_high", k), hi, vecs[k].exp_hi);
            chk($sformatf("vec%0d_pe_count", k), pe, 1);
            chk($sformatf("vec%0d_next_pe", k), int'(period_end), 1);
        end

        // Mid-period write of 10 at cnt=5 while running at 4.
        period_run(15, 5'd10, -1, '0, hi, pe, ak, bz);
        chk("mid_cur_high", hi, 12);
        chk("mid_cur_ack",  ak, 0);
        chk("mid_busy_len", bz, 32);
        chk("mid_wrap_ack",  int'(duty_ack),  1);
        chk("mid_wrap_busy", int'(duty_busy), 0);
        period_run(-1, '0, -1, '0, hi, pe, ak, bz);
        chk("mid_next_high", hi, 30);
        chk("mid_next_acks", ak, 1);

        // Two writes in one period: last wins, single ack.
        period_run(5, 5'd6, 20, 5'd9, hi, pe, ak, bz);
        chk("two_cur_high", hi, 30);
        chk("two_busy_len", bz, 42);
        chk("two_wrap_ack", int'(duty_ack), 1);
        period_run(-1, '0, -1, '0, hi, pe, ak, bz);
        chk("two_next_high", hi, 27);
        chk("two_next_acks", ak, 1);

        // Write landing on the wrap edge: bypass.
        period_run(47, 5'd12, -1, '0, hi, pe, ak, bz);
        chk("wrapwr_cur_high", hi, 27);
        chk("wrapwr_busy_len", bz, 0);
        chk("wrapwr_ack",  int'(duty_ack),  1);
        chk("wrapwr_busy", int'(duty_busy), 0);

        // en drop at cnt=7 with duty 12.
        repeat (21) @(negedge clk);
        chk("endrop_pre_pwm", int'(pwm_out), 1);
        en = 1'b0;
        @(negedge clk);
        chk("endrop_pwm", int'(pwm_out), 0);
        duty_wr = 1'b1; duty_in = 5'd5;
        @(negedge clk);
        duty_wr = 1'b0;
        chk("idle_wr_busy", int'(duty_busy), 1);
        en = 1'b1;
        @(negedge clk);
        chk("rerun_ack",  int'(duty_ack),  1);
        chk("rerun_busy", int'(duty_busy), 0);
        chk("rerun_pwm",  int'(pwm_out),   1);
        ticks = 0; n = 0;
        while (pwm_out && n < 100) begin
            ticks += int'(tick);
            n++;
            @(negedge clk);
        end
        chk("rerun_high_ticks", ticks, 5);

        // Asynchronous reset mid-RUN with a pending duty.
        wait_pe("pre_reset_pe");
        duty_wr = 1'b1; duty_in = 5'd8;
        @(negedge clk);
        duty_wr = 1'b0;
        chk("pre_reset_busy", int'(duty_busy), 1);
        chk("pre_reset_pwm",  int'(pwm_out),   1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_pwm",  int'(pwm_out),    0);
        chk("async_busy", int'(duty_busy),  0);
        chk("async_ack",  int'(duty_ack),   0);
        chk("async_pe",   int'(period_end), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        ticks = 0; hi = 0; ak = 0; n = 0;
        while (!period_end && n < 300) begin
            ticks += int'(tick);
            hi    += int'(pwm_out);
            ak    += int'(duty_ack);
            n++;
            @(negedge clk);
        end
        chk("post_reset_ticks", ticks, 16);
        chk("post_reset_high",  hi, 0);
        chk("post_reset_acks",  ak, 0);
        chk("post_reset_busy",  int'(duty_busy), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
